run_timer: RTL and testbench

// - Elapsed-run timer for the Runner game; sits directly downstream of the 10 ms tick divider.
// - Counts the divider's tick pulses into BCD MM:SS.CC (minutes, seconds, centiseconds) on the system clock.
// - Runs a start/pause/stop/clear FSM and holds the best (lowest) finished run time for the score display.

---
 rtl/run_timer_if.sv | 34 +++
 rtl/run_timer.sv | 179 +++++++++++++++++
 tb/tb_run_timer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_timer_if.sv
// run_timer_if: command/tick inputs and time/best outputs of the Runner elapsed-run timer.
//   tick_10ms  10 ms tick pulse from the divider (asynchronous to clk)
//   start      start/resume request
//   pause      pause request
//   stop       end of run
//   clear      return to idle and zero the time
//   time_bcd   {min_t,min_u,sec_t,sec_u,cs_t,cs_u}, 4 bits per BCD digit
//   running    1 while the timer is in the running state
//   overflow   sticky saturation flag
//   best_bcd   best finished time, same digit format as time_bcd
//   new_best   one-clk pulse when best_bcd is updated
// master: the controller driving commands; slave: the timer itself.
interface run_timer_if;
    logic        tick_10ms;
    logic        start;
    logic        pause;
    logic        stop;
    logic        clear;
    logic [23:0] time_bcd;
    logic        running;
    logic        overflow;
    logic [23:0] best_bcd;
    logic        new_best;

    modport master (
        output tick_10ms, start, pause, stop, clear,
        input  time_bcd, running, overflow, best_bcd, new_best
    );

    modport slave (
        input  tick_10ms, start, pause, stop, clear,
        output time_bcd, running, overflow, best_bcd, new_best
    );
endinterface

// File: rtl/run_timer.sv
// run_timer: elapsed-run timer for the Runner game.
// Synchronises the 10 ms divider tick, edge-detects it into a one-clk tick and counts it
// in BCD MM:SS.CC under a start/pause/stop/clear FSM. Optionally keeps the best
// (lowest) finished, non-overflowed run time.
// Ports:
//   clk     system clock
//   reset   asynchronous, active-high reset
//   io_bus  run_timer_if.slave (tick_10ms, start, pause, stop, clear in;
//           time_bcd, running, overflow, best_bcd, new_best out)
// Parameters:
//   SYNC_STAGES  synchroniser depth on tick_10ms (2..4)
//   MAX_MIN      minute value at which the count saturates (0..59)
// Configuration macro:
//   BEST_TIME_EN  defined: best-time register, comparator and new_best pulse are built.
//                 undefined: best_bcd reads 0 and new_best stays 0.
module run_timer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_MIN     = 59
) (
    input logic         clk,
    input logic         reset,
    run_timer_if.slave  io_bus
);

    localparam logic [3:0]  MAX_MIN_T = 4'(MAX_MIN / 10);
    localparam logic [3:0]  MAX_MIN_U = 4'(MAX_MIN % 10);
    localparam logic [23:0] SAT_VALUE = {MAX_MIN_T, MAX_MIN_U, 4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {StIdle, StRunning, StPaused, StStopped} state_e;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_tick_prev;
    logic                   w_tk;
    logic                   w_sat;
    state_e                 r_state;
    logic [23:0]            r_time;
    logic                   r_running;
    logic                   r_overflow;

    // BCD increment with digit-wise carry; minutes never pass 59 because of saturation.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] n;
        n = t;
        if (t[3:0] != 4'd9) begin
            n[3:0] = t[3:0] + 4'd1;
        end else begin
            n[3:0] = 4'd0;
            if (t[7:4] != 4'd9) begin
                n[7:4] = t[7:4] + 4'd1;
            end else begin
                n[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    n[11:8] = t[11:8] + 4'd1;
                end else begin
                    n[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) begin
                        n[15:12] = t[15:12] + 4'd1;
                    end else begin
                        n[15:12] = 4'd0;
                        if (t[19:16] != 4'd9) begin
                            n[19:16] = t[19:16] + 4'd1;
                        end else begin
                            n[19:16] = 4'd0;
                            n[23:20] = t[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    // Tick synchroniser and rising-edge detect: one tk per pulse whatever its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync      <= '0;
            r_tick_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], io_bus.tick_10ms};
            r_tick_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tk  = r_sync[SYNC_STAGES-1] & ~r_tick_prev;
    assign w_sat = (r_time == SAT_VALUE);

    // Control FSM with registered outputs. Commands take precedence over a coincident tk,
    // so a tick arriving with stop/pause/clear/start-from-idle-or-paused is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_time     <= '0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (io_bus.clear) begin
            r_state    <= StIdle;
            r_time     <= '0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_state   <= StRunning;
                        r_running <= 1'b1;
                    end
                end
                StRunning: begin
                    if (io_bus.stop) begin
                        r_state   <= StStopped;
                        r_running <= 1'b0;
                    end else if (io_bus.pause) begin
                        r_state   <= StPaused;
                        r_running <= 1'b0;
                    end else if (w_tk) begin
                        if (w_sat) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_time <= bcd_inc(r_time);
                        end
                    end
                end
                StPaused: begin
                    if (io_bus.stop) begin
                        r_state <= StStopped;
                    end else if (io_bus.start) begin
                        r_state   <= StRunning;
                        r_running <= 1'b1;
                    end
                end
                StStopped: begin
                    // Only clear leaves this state.
                end
                default: begin
                    r_state   <= StIdle;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.time_bcd = r_time;
    assign io_bus.running  = r_running;
    assign io_bus.overflow = r_overflow;

`ifdef BEST_TIME_EN
    logic        w_to_stopped;
    logic [23:0] r_best;
    logic        r_best_valid;
    logic        r_new_best;

    // Same condition the FSM uses to enter StStopped; the time is frozen that cycle.
    assign w_to_stopped = !io_bus.clear && io_bus.stop &&
                          ((r_state == StRunning) || (r_state == StPaused));

    // Plain unsigned compare orders packed BCD values correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best       <= '0;
            r_best_valid <= 1'b0;
            r_new_best   <= 1'b0;
        end else begin
            r_new_best <= 1'b0;
            if (w_to_stopped && !r_overflow && (!r_best_valid || (r_time < r_best))) begin
                r_best       <= r_time;
                r_best_valid <= 1'b1;
                r_new_best   <= 1'b1;
            end
        end
    end

    assign io_bus.best_bcd = r_best;
    assign io_bus.new_best = r_new_best;
`else
    assign io_bus.best_bcd = 24'h0;
    assign io_bus.new_best = 1'b0;
`endif

endmodule

// File: tb/tb_run_timer.sv
// tb_run_timer: self-checking bench for run_timer.
// The reference model tracks elapsed time as an integer number of centiseconds and
// converts it to BCD arithmetically; FSM behaviour is modelled from the command rules.
// Works with or without BEST_TIME_EN defined.
module tb_run_timer;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned MAXM  = 1;
    localparam int          LIMIT = MAXM * 6000 + 5999;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_STOP  = 3;

`ifdef BEST_TIME_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    run_timer_if bus ();

    run_timer #(
        .SYNC_STAGES (SYNC),
        .MAX_MIN     (MAXM)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_state;
    int m_cs;
    int m_best;
    bit m_ovf;
    bit m_bv;
    bit m_nb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int cs);
        int mn, sc, cc;
        mn = cs / 6000;
        sc = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic logic [23:0] exp_best();
        return (BEST_EN && m_bv) ? to_bcd(m_best) : 24'h0;
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE;
        m_cs    = 0;
        m_ovf   = 1'b0;
        m_best  = 0;
        m_bv    = 1'b0;
        m_nb    = 1'b0;
    endtask

    task automatic model_count();
        if (m_state == ST_RUN) begin
            if (m_cs == LIMIT) m_ovf = 1'b1;
            else m_cs++;
        end
    endtask

    // One clock's worth of commands (priority clear > stop > pause > start) plus optional tk.
    task automatic model_cmd(input bit s, input bit p, input bit t, input bit c, input bit tk);
        m_nb = 1'b0;
        if (c) begin
            m_state = ST_IDLE;
            m_cs    = 0;
            m_ovf   = 1'b0;
        end else if (t && (m_state == ST_RUN || m_state == ST_PAUSE)) begin
            m_state = ST_STOP;
            if (!m_ovf && (!m_bv || m_cs < m_best)) begin
                m_best = m_cs;
                m_bv   = 1'b1;
                m_nb   = 1'b1;
            end
        end else if (p && m_state == ST_RUN) begin
            m_state = ST_PAUSE;
        end else if (s && (m_state == ST_IDLE || m_state == ST_PAUSE)) begin
            m_state = ST_RUN;
        end else if (tk) begin
            model_count();
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".time"}, 32'(bus.time_bcd), 32'(to_bcd(m_cs)));
        check_eq({tag, ".running"}, 32'(bus.running), (m_state == ST_RUN) ? 32'd1 : 32'd0);
        check_eq({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        check_eq({tag, ".best"}, 32'(bus.best_bcd), 32'(exp_best()));
    endtask

    task automatic set_cmd(input bit s, input bit p, input bit t, input bit c);
        bus.start = s;
        bus.pause = p;
        bus.stop  = t;
        bus.clear = c;
    endtask

    // Single-cycle command pulse; checks state, new_best pulse and its one-clk width.
    task automatic do_cmd(input string tag, input bit s, input bit p, input bit t, input bit c);
        set_cmd(s, p, t, c);
        @(negedge clk);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0);
        model_cmd(s, p, t, c, 1'b0);
        check_all(tag);
        check_eq({tag, ".new_best"}, 32'(bus.new_best), 32'(BEST_EN && m_nb));
        @(negedge clk);
        check_eq({tag, ".new_best_end"}, 32'(bus.new_best), 32'd0);
    endtask

    task automatic do_tick(input int w);
        bus.tick_10ms = 1'b1;
        repeat (w) @(negedge clk);
        bus.tick_10ms = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        model_count();
    endtask

    task automatic fast_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_10ms = 1'b1;
            @(negedge clk);
            bus.tick_10ms = 1'b0;
            @(negedge clk);
            model_count();
        end
        repeat (SYNC + 2) @(negedge clk);
    endtask

    // Command lands in the very cycle the internal tick is high.
    task automatic tick_with_cmd(input string tag, input bit s, input bit p, input bit t,
                                 input bit c);
        bus.tick_10ms = 1'b1;
        repeat (SYNC) @(negedge clk);
        set_cmd(s, p, t, c);
        @(negedge clk);
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0);
        bus.tick_10ms = 1'b0;
        model_cmd(s, p, t, c, 1'b1);
        check_all(tag);
        check_eq({tag, ".new_best"}, 32'(bus.new_best), 32'(BEST_EN && m_nb));
        repeat (SYNC + 2) @(negedge clk);
        check_all({tag, ".settle"});
    endtask

    task automatic reset_dut(input string tag);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_all(tag);
        check_eq({tag, ".new_best"}, 32'(bus.new_best), 32'd0);
    endtask

    initial begin
        int r;
        bus.tick_10ms = 1'b0;
        set_cmd(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all("reset");
        check_eq("reset.new_best", 32'(bus.new_best), 32'd0);

        // 1: start and 150 ticks of random width
        do_cmd("t1.start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) do_tick(int'($urandom_range(1, 5)));
        check_all("t1.run");
        check_eq("t1.time150", 32'(bus.time_bcd), 32'h000150);

        // 2: latency and a wide pulse giving one increment
        bus.tick_10ms = 1'b1;
        repeat (SYNC) @(negedge clk);
        check_eq("t2.lat_early", 32'(bus.time_bcd), 32'(to_bcd(m_cs)));
        @(negedge clk);
        model_count();
        check_eq("t2.lat_upd", 32'(bus.time_bcd), 32'(to_bcd(m_cs)));
        repeat (5 - SYNC - 1) @(negedge clk);
        bus.tick_10ms = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        check_all("t2.wide");
        check_eq("t2.time151", 32'(bus.time_bcd), 32'h000151);

        // 3: minute carry, saturation, overflowed stop, clear
        do_cmd("t3.clear", 1'b0, 1'b0, 1'b0, 1'b1);
        do_cmd("t3.start", 1'b1, 1'b0, 1'b0, 1'b0);
        fast_ticks(5999);
        check_eq("t3.005999", 32'(bus.time_bcd), 32'h005999);
        do_tick(1);
        check_eq("t3.010000", 32'(bus.time_bcd), 32'h010000);
        fast_ticks(5999);
        check_all("t3.max");
        do_tick(2);
        check_all("t3.sat");
        check_eq("t3.sat_time", 32'(bus.time_bcd), 32'h015999);
        check_eq("t3.ovf", 32'(bus.overflow), 32'd1);
        do_tick(1);
        check_all("t3.sat2");
        do_cmd("t3.stop_ovf", 1'b0, 1'b0, 1'b1, 1'b0);
        do_cmd("t3.clear2", 1'b0, 1'b0, 1'b0, 1'b1);

        // 4: pause, resume, coincident start/stop with tk, stopped ignores all
        do_cmd("t4.start", 1'b1, 1'b0, 1'b0, 1'b0);
        fast_ticks(25);
        do_cmd("t4.pause", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) do_tick(1);
        check_all("t4.paused");
        do_cmd("t4.resume", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) do_tick(2);
        check_all("t4.resumed");
        do_cmd("t4.pause2", 1'b0, 1'b1, 1'b0, 1'b0);
        tick_with_cmd("t4.start_tk", 1'b1, 1'b0, 1'b0, 1'b0);
        do_tick(1);
        check_all("t4.after_start_tk");
        tick_with_cmd("t4.stop_tk", 1'b0, 1'b0, 1'b1, 1'b0);
        do_tick(1);
        check_all("t4.stopped_tick");
        do_cmd("t4.stopped_start", 1'b1, 1'b0, 1'b0, 1'b0);
        // priority combinations
        do_cmd("t4.clear", 1'b0, 1'b0, 1'b0, 1'b1);
        do_cmd("t4.start2", 1'b1, 1'b0, 1'b0, 1'b0);
        fast_ticks(7);
        do_cmd("t4.pause_start", 1'b1, 1'b1, 1'b0, 1'b0);
        do_cmd("t4.resume2", 1'b1, 1'b0, 1'b0, 1'b0);
        do_cmd("t4.stop_pause_start", 1'b1, 1'b1, 1'b1, 1'b0);
        do_cmd("t4.all", 1'b1, 1'b1, 1'b1, 1'b1);

        // 5: best-time tracking
        reset_dut("t5.reset");
        do_cmd("t5.start1", 1'b1, 1'b0, 1'b0, 1'b0);
        fast_ticks(200);
        do_cmd("t5.stop1", 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t5.best200", 32'(bus.best_bcd), BEST_EN ? 32'h000200 : 32'h0);
        do_cmd("t5.clear1", 1'b0, 1'b0, 1'b0, 1'b1);
        do_cmd("t5.start2", 1'b1, 1'b0, 1'b0, 1'b0);
        fast_ticks(300);
        do_cmd("t5.stop2", 1'b0, 1'b0, 1'b1, 1'b0);
        do_cmd("t5.clear2", 1'b0, 1'b0, 1'b0, 1'b1);
        do_cmd("t5.start3", 1'b1, 1'b0, 1'b0, 1'b0);
        fast_ticks(150);
        do_cmd("t5.stop3", 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t5.best150", 32'(bus.best_bcd), BEST_EN ? 32'h000150 : 32'h0);

        // Random single-command / tick sequence against the model
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 12) begin
                do_tick(int'($urandom_range(1, 5)));
                check_all("rnd.tick");
            end else if (r < 15) begin
                do_cmd("rnd.start", 1'b1, 1'b0, 1'b0, 1'b0);
            end else if (r < 17) begin
                do_cmd("rnd.pause", 1'b0, 1'b1, 1'b0, 1'b0);
            end else if (r < 19) begin
                do_cmd("rnd.stop", 1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
                do_cmd("rnd.clear", 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end

        // 6: asynchronous reset mid-run
        do_cmd("t6.clear", 1'b0, 1'b0, 1'b0, 1'b1);
        do_cmd("t6.start", 1'b1, 1'b0, 1'b0, 1'b0);
        fast_ticks(37);
        check_all("t6.pre");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        check_eq("t6.new_best", 32'(bus.new_best), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_tick(1);
        check_all("t6.idle_tick");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
